// File: rtl/activation_scheduler.sv
// activation_scheduler
//   Lets NUM_REQ neuron requesters share one sigmoid/tanh lookup unit.
//   A round-robin arbiter picks a requester in IDLE. Its sum and function
//   select are latched and held on the lookup interface until the response
//   leaves. The result comes back tagged with the requester index through a
//   valid/ready port. A watchdog turns a silent lookup unit into a
//   timed-out response, so the layer cannot hang.
//
// Ports
//   clock, reset_n     rising-edge clock, async active-low reset
//   req/req_sum/       per-requester level request, packed sums
//   req_func           (slice i at [i*DATAWIDTH +: DATAWIDTH]) and func select
//   ack                one-cycle capture pulse, one-hot
//   lut_sum/lut_func/  operands and start pulse to the lookup unit
//   lut_start
//   lut_value/lut_done result and its one-cycle valid from the lookup unit
//   rsp_valid/         response handshake
//   rsp_ready
//   rsp_id/rsp_value/  requester index, activation value, watchdog abort flag
//   rsp_timeout
module activation_scheduler #(
  parameter int DATAWIDTH = 16,
  parameter int NUM_REQ   = 4,
  parameter int ID_WIDTH  = 2,
  parameter int TIMEOUT   = 64,
  parameter int CNT_WIDTH = 7
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*DATAWIDTH-1:0]   req_sum,
  input  logic [NUM_REQ-1:0]             req_func,
  output logic [NUM_REQ-1:0]             ack,
  output logic [DATAWIDTH-1:0]           lut_sum,
  output logic                           lut_func,
  output logic                           lut_start,
  input  logic [DATAWIDTH-1:0]           lut_value,
  input  logic                           lut_done,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [ID_WIDTH-1:0]            rsp_id,
  output logic [DATAWIDTH-1:0]           rsp_value,
  output logic                           rsp_timeout
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t                          state;
  logic [ID_WIDTH-1:0]             rr_ptr;
  logic [CNT_WIDTH-1:0]            wd_cnt;

  // Per-requester view of the packed sum bus.
  logic [NUM_REQ-1:0][DATAWIDTH-1:0] sum_arr;
  assign sum_arr = req_sum;

  // Round-robin pick. Scanning from the top down leaves the lowest set
  // index in each candidate: g_hi is the lowest at/above rr_ptr, g_lo the
  // lowest overall, which is the wrap-around choice. Only indices below
  // NUM_REQ are scanned, so an out-of-range ID can never be granted.
  logic                hit_hi, any_req;
  logic [ID_WIDTH-1:0] g_hi, g_lo, grant;

  always_comb begin
    hit_hi  = 1'b0;
    any_req = 1'b0;
    g_hi    = '0;
    g_lo    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        any_req = 1'b1;
        g_lo    = ID_WIDTH'(i);
        if (ID_WIDTH'(i) >= rr_ptr) begin
          hit_hi = 1'b1;
          g_hi   = ID_WIDTH'(i);
        end
      end
    end
    grant = hit_hi ? g_hi : g_lo;
  end

  // rsp_id still holds the granted index in RESP, so it also seeds the
  // next round-robin start.
  logic [ID_WIDTH-1:0] rr_next;
  assign rr_next = (rsp_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : rsp_id + ID_WIDTH'(1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      rr_ptr      <= '0;
      wd_cnt      <= '0;
      ack         <= '0;
      lut_sum     <= '0;
      lut_func    <= 1'b0;
      lut_start   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_value   <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      // ack and lut_start are single-cycle pulses, raised only on grant.
      ack       <= '0;
      lut_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (any_req) begin
            ack       <= NUM_REQ'(1) << grant;
            lut_sum   <= sum_arr[grant];
            lut_func  <= req_func[grant];
            rsp_id    <= grant;
            lut_start <= 1'b1;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          wd_cnt <= '0;
          state  <= S_WAIT;
        end
        S_WAIT: begin
          // A done on the last watchdog cycle still delivers real data.
          if (lut_done) begin
            rsp_value   <= lut_value;
            rsp_timeout <= 1'b0;
            rsp_valid   <= 1'b1;
            state       <= S_RESP;
          end else if (wd_cnt == CNT_WIDTH'(TIMEOUT - 1)) begin
            rsp_value   <= '0;
            rsp_timeout <= 1'b1;
            rsp_valid   <= 1'b1;
            state       <= S_RESP;
          end else begin
            wd_cnt <= wd_cnt + CNT_WIDTH'(1);
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rr_ptr    <= rr_next;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_activation_scheduler.sv
module tb_activation_scheduler;
  localparam int DW = 16;
  localparam int NR = 4;
  localparam int IW = 2;

  logic              clock = 1'b0;
  logic              reset_n;
  logic [NR-1:0]     req;
  logic [NR*DW-1:0]  req_sum;
  logic [NR-1:0]     req_func;
  logic [NR-1:0]     ack;
  logic [DW-1:0]     lut_sum;
  logic              lut_func;
  logic              lut_start;
  logic [DW-1:0]     lut_value;
  logic              lut_done;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IW-1:0]     rsp_id;
  logic [DW-1:0]     rsp_value;
  logic              rsp_timeout;

  int passed = 0;
  int total  = 0;

  activation_scheduler #(
    .DATAWIDTH(DW), .NUM_REQ(NR), .ID_WIDTH(IW), .TIMEOUT(64), .CNT_WIDTH(7)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .req(req), .req_sum(req_sum), .req_func(req_func), .ack(ack),
    .lut_sum(lut_sum), .lut_func(lut_func), .lut_start(lut_start),
    .lut_value(lut_value), .lut_done(lut_done),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_value(rsp_value), .rsp_timeout(rsp_timeout)
  );

  always #5 clock = ~clock;

  // Inputs are driven and outputs sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  // Bounded wait for any ack; the caller checks the ack value, so an
  // expired bound shows up as a failed comparison.
  task automatic wait_ack();
    for (int k = 0; k < 30; k++) begin
      if (ack != '0) break;
      tick();
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    total++;
    if ({ack, lut_sum, lut_func, lut_start, rsp_valid, rsp_id, rsp_value, rsp_timeout} !== '0)
      $display("FAIL reset_outputs got ack=%b lut_sum=%h start=%b valid=%b id=%0d val=%h to=%b exp all 0",
               ack, lut_sum, lut_start, rsp_valid, rsp_id, rsp_value, rsp_timeout);
    else passed++;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    req_sum = {16'h0400, 16'h0800, 16'h0200, 16'h0100};
    req_func = 4'b0000;
    req = 4'b0100;
    tick();                                      // cycle 1
    total++;
    if (ack !== 4'b0100) $display("FAIL single_ack got=%b exp=0100", ack); else passed++;
    total++;
    if (lut_start !== 1'b1) $display("FAIL single_start got=%b exp=1", lut_start); else passed++;
    total++;
    if ({lut_sum, lut_func} !== {16'h0800, 1'b0})
      $display("FAIL single_lut_op got=%h/%b exp=0800/0", lut_sum, lut_func);
    else passed++;
    req = 4'b0000;
    tick();                                      // cycle 2
    total++;
    if ({ack, lut_start} !== 5'b0) $display("FAIL single_pulse_width got ack=%b start=%b exp 0", ack, lut_start);
    else passed++;
    repeat (4) tick();                           // cycle 6
    lut_done = 1'b1;
    lut_value = 16'h2EC8;
    total++;
    if (rsp_valid !== 1'b0) $display("FAIL single_early_valid got=%b exp=0", rsp_valid); else passed++;
    tick();                                      // cycle 7
    lut_done = 1'b0;
    lut_value = 16'h0000;
    total++;
    if ({rsp_valid, rsp_id, rsp_value, rsp_timeout} !== {1'b1, 2'd2, 16'h2EC8, 1'b0})
      $display("FAIL single_rsp got valid=%b id=%0d val=%h to=%b exp 1/2/2ec8/0",
               rsp_valid, rsp_id, rsp_value, rsp_timeout);
    else passed++;
    total++;
    if (lut_sum !== 16'h0800) $display("FAIL single_lut_hold got=%h exp=0800", lut_sum); else passed++;
    rsp_ready = 1'b1;
    tick();                                      // cycle 8
    total++;
    if (rsp_valid !== 1'b0) $display("FAIL single_rsp_clear got=%b exp=0", rsp_valid); else passed++;
    rsp_ready = 1'b0;
  endtask

  task automatic test_round_robin();
    int order [5] = '{0, 1, 2, 3, 0};
    logic [DW-1:0] sums [4] = '{16'h0101, 16'h0202, 16'h0303, 16'h0404};
    logic [3:0] funcs = 4'b1010;
    do_reset();
    for (int i = 0; i < 4; i++) req_sum[i*DW +: DW] = sums[i];
    req_func = funcs;
    rsp_ready = 1'b1;
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      int e;
      logic [3:0] exp_ack;
      e = order[n];
      exp_ack = 4'b0001 << e;
      wait_ack();
      total++;
      if (ack !== exp_ack) $display("FAIL rr_ack[%0d] got=%b exp=%b", n, ack, exp_ack); else passed++;
      total++;
      if ({lut_sum, lut_func} !== {sums[e], funcs[e]})
        $display("FAIL rr_lut_op[%0d] got=%h/%b exp=%h/%b", n, lut_sum, lut_func, sums[e], funcs[e]);
      else passed++;
      if (n == 4) req = 4'b0000;
      repeat (3) tick();
      lut_done = 1'b1;
      lut_value = 16'h3000 + 16'(n);
      tick();
      lut_done = 1'b0;
      total++;
      if ({rsp_valid, rsp_id, rsp_value} !== {1'b1, 2'(e), 16'h3000 + 16'(n)})
        $display("FAIL rr_rsp[%0d] got valid=%b id=%0d val=%h exp 1/%0d/%h",
                 n, rsp_valid, rsp_id, rsp_value, e, 16'h3000 + 16'(n));
      else passed++;
    end
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic hold_ok;
    req_sum = {16'h0D00, 16'h0C00, 16'h0B00, 16'h0A00};
    req_func = 4'b0000;
    req = 4'b0001;
    wait_ack();
    total++;
    if (ack !== 4'b0001) $display("FAIL bp_ack got=%b exp=0001", ack); else passed++;
    req = 4'b0000;
    tick();
    tick();
    lut_done = 1'b1;
    lut_value = 16'h0ABC;
    tick();
    lut_done = 1'b0;
    total++;
    if (rsp_valid !== 1'b1) $display("FAIL bp_valid got=%b exp=1", rsp_valid); else passed++;
    req = 4'b1000;                               // raised during RESP
    hold_ok = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if ({rsp_valid, rsp_id, rsp_value, rsp_timeout, ack} !== {1'b1, 2'd0, 16'h0ABC, 1'b0, 4'b0000})
        hold_ok = 1'b0;
    end
    total++;
    if (hold_ok !== 1'b1)
      $display("FAIL bp_hold got valid=%b id=%0d val=%h to=%b ack=%b exp 1/0/0abc/0/0000",
               rsp_valid, rsp_id, rsp_value, rsp_timeout, ack);
    else passed++;
    rsp_ready = 1'b1;
    tick();                                      // IDLE
    total++;
    if ({rsp_valid, ack} !== 5'b0) $display("FAIL bp_idle got valid=%b ack=%b exp 0/0000", rsp_valid, ack);
    else passed++;
    tick();                                      // ISSUE for requester 3
    total++;
    if ({ack, lut_sum} !== {4'b1000, 16'h0D00})
      $display("FAIL bp_late_ack got=%b/%h exp=1000/0d00", ack, lut_sum);
    else passed++;
    req = 4'b0000;
    tick();
    lut_done = 1'b1;
    lut_value = 16'h0333;
    tick();
    lut_done = 1'b0;
    total++;
    if ({rsp_valid, rsp_id, rsp_value} !== {1'b1, 2'd3, 16'h0333})
      $display("FAIL bp_second_rsp got %b/%0d/%h exp 1/3/0333", rsp_valid, rsp_id, rsp_value);
    else passed++;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_timeout();
    logic quiet;
    req = 4'b0010;
    wait_ack();
    total++;
    if (ack !== 4'b0010) $display("FAIL to_ack got=%b exp=0010", ack); else passed++;
    req = 4'b0000;
    repeat (64) tick();                          // 63 cycles after WAIT entry
    total++;
    if (rsp_valid !== 1'b0) $display("FAIL to_early got=%b exp=0", rsp_valid); else passed++;
    tick();                                      // 64 cycles after WAIT entry
    total++;
    if ({rsp_valid, rsp_id, rsp_value, rsp_timeout} !== {1'b1, 2'd1, 16'h0000, 1'b1})
      $display("FAIL to_rsp got valid=%b id=%0d val=%h to=%b exp 1/1/0000/1",
               rsp_valid, rsp_id, rsp_value, rsp_timeout);
    else passed++;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    tick();
    tick();                                      // 3 cycles after the response
    lut_done = 1'b1;
    lut_value = 16'h5555;
    tick();
    lut_done = 1'b0;
    quiet = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if ({rsp_valid, ack} !== 5'b0) quiet = 1'b0;
      tick();
    end
    total++;
    if (quiet !== 1'b1) $display("FAIL to_late_done got valid=%b ack=%b exp no response", rsp_valid, ack);
    else passed++;
  endtask

  task automatic test_done_at_timeout();
    req = 4'b0100;
    wait_ack();
    total++;
    if (ack !== 4'b0100) $display("FAIL dt_ack got=%b exp=0100", ack); else passed++;
    req = 4'b0000;
    repeat (64) tick();                          // wd_cnt == 63
    lut_done = 1'b1;
    lut_value = 16'h1234;
    tick();
    lut_done = 1'b0;
    total++;
    if ({rsp_valid, rsp_value, rsp_timeout} !== {1'b1, 16'h1234, 1'b0})
      $display("FAIL dt_rsp got valid=%b val=%h to=%b exp 1/1234/0", rsp_valid, rsp_value, rsp_timeout);
    else passed++;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    req_sum = {16'h0F00, 16'h0E00, 16'h7777, 16'h0900};
    req_func = 4'b0010;
    req = 4'b0010;
    wait_ack();
    req = 4'b0000;
    tick();
    tick();                                      // in WAIT
    total++;
    if ({lut_sum, lut_func} !== {16'h7777, 1'b1})
      $display("FAIL rst_pre got=%h/%b exp=7777/1", lut_sum, lut_func);
    else passed++;
    reset_n = 1'b0;
    #1;
    total++;
    if ({ack, lut_sum, lut_func, lut_start, rsp_valid, rsp_id, rsp_value, rsp_timeout} !== '0)
      $display("FAIL rst_async got lut_sum=%h func=%b id=%0d val=%h to=%b exp all 0",
               lut_sum, lut_func, rsp_id, rsp_value, rsp_timeout);
    else passed++;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    // rr_ptr was 3 before reset; from 0 the pick among {1,3} is 1.
    req = 4'b1010;
    wait_ack();
    total++;
    if (ack !== 4'b0010) $display("FAIL rst_regrant got=%b exp=0010", ack); else passed++;
    req = 4'b0000;
    tick();
    lut_done = 1'b1;
    lut_value = 16'h0042;
    tick();
    lut_done = 1'b0;
    total++;
    if ({rsp_valid, rsp_id, rsp_value} !== {1'b1, 2'd1, 16'h0042})
      $display("FAIL rst_rsp got %b/%0d/%h exp 1/1/0042", rsp_valid, rsp_id, rsp_value);
    else passed++;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    reset_n   = 1'b0;
    req       = '0;
    req_sum   = '0;
    req_func  = '0;
    lut_value = '0;
    lut_done  = 1'b0;
    rsp_ready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_timeout();
    test_done_at_timeout();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/activation_scheduler.md
Name: activation_scheduler

Overview:
Time-shares one activation lookup unit (sigmoid/tanh closest-value search) between NUM_REQ neuron requesters. It selects a requester by round-robin, presents that requester's sum and function select to the lookup unit, and holds them stable until the unit signals done. It then returns the activation value tagged with the requester ID through a valid/ready response port. A watchdog bounds the wait so a silent lookup unit cannot hang the layer.

Parameters:
DATAWIDTH, 16, width of sum and activation value (sum Q5.11, value Q2.14)
NUM_REQ, 4, number of requesters (2..8)
ID_WIDTH, 2, width of requester ID; must satisfy 2**ID_WIDTH >= NUM_REQ
TIMEOUT, 64, maximum cycles in WAIT before abort (>= 2)
CNT_WIDTH, 7, watchdog counter width; must satisfy 2**CNT_WIDTH > TIMEOUT

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
req  in  NUM_REQ  per-requester request, level; held until matching ack
req_sum  in  NUM_REQ*DATAWIDTH  packed sums; requester i occupies bits [i*DATAWIDTH +: DATAWIDTH]
req_func  in  NUM_REQ  per-requester function select (0 sigmoid, 1 tanh)
ack  out  NUM_REQ  one-cycle pulse: the request was captured
lut_sum  out  DATAWIDTH  sum driven to the lookup unit
lut_func  out  1  function select driven to the lookup unit
lut_start  out  1  one-cycle start pulse to the lookup unit
lut_value  in  DATAWIDTH  lookup result
lut_done  in  1  lookup result valid, one-cycle pulse
rsp_valid  out  1  response valid
rsp_ready  in  1  consumer accepts the response
rsp_id  out  ID_WIDTH  requester index of the response
rsp_value  out  DATAWIDTH  activation value
rsp_timeout  out  1  response is an aborted lookup

Behaviour:
- Reset (async assert, sync deassert by the caller) drives these values:
  - state = IDLE, rr_ptr = 0, wd_cnt = 0
  - all outputs 0
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req bit is set, grant the lowest index g >= rr_ptr with req[g]=1, wrapping to 0 if none is found.
  - Latch req_sum slice g into lut_sum, req_func[g] into lut_func, and g into rsp_id.
  - Pulse ack[g] on the next cycle; go to ISSUE.
  - If no req bit is set, stay in IDLE.
- ISSUE: lut_start=1 for exactly this cycle; clear wd_cnt; go to WAIT.
- lut_sum and lut_func hold stable from ISSUE entry until RESP exit. They only change on the next grant.
- WAIT:
  - If lut_done=1: latch lut_value into rsp_value, set rsp_timeout=0, go to RESP.
  - Else, if wd_cnt == TIMEOUT-1: set rsp_value=0, rsp_timeout=1, go to RESP.
  - Else wd_cnt++.
  - lut_done and timeout in the same cycle: lut_done wins.
- lut_done outside WAIT is ignored. A late done that arrives after a timeout is discarded.
- RESP:
  - rsp_valid=1. rsp_id, rsp_value and rsp_timeout stay stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_ready=1: clear rsp_valid, set rr_ptr = (g+1) mod NUM_REQ, go to IDLE.
- Latency: req seen in IDLE at cycle 0.
  - ack and state ISSUE at cycle 1; lut_start at cycle 1.
  - lut_done at cycle 1+L gives rsp_valid at cycle 2+L.
- Throughput: one lookup in flight. Minimum 4 cycles per lookup plus lookup-unit latency, with one IDLE bubble after each response.
- New requests arriving during ISSUE, WAIT or RESP are not captured. The requester keeps req high and is arbitrated in the next IDLE.
- Requester protocol:
  - Dropping req before ack withdraws the request with no side effects.
  - Keeping req high after ack issues a new request.
- Fairness: with all requesters continuously active, grants rotate 0,1,...,NUM_REQ-1,0,...
- A reset mid-operation aborts the in-flight lookup silently: no ack, no response, rr_ptr returns to 0.
- Out-of-range IDs (g >= NUM_REQ) are never granted.

Test Plan:
- Single request: req=4'b0100, req_sum[2]=16'h0800 (1.0), func=0, lookup unit returns 16'h2EC8 after L=5 → ack=4'b0100 at cycle 1, lut_start at cycle 1, rsp_valid at cycle 7 with rsp_id=2, rsp_value=16'h2EC8, rsp_timeout=0.
- Round-robin: req=4'b1111 held, rsp_ready=1, L=3 → grant order 0,1,2,3,0; each lut_sum equals the corresponding req_sum slice; no requester is skipped.
- Backpressure: rsp_ready=0 for 10 cycles after rsp_valid → rsp_id, rsp_value and rsp_timeout stay constant; a req raised during RESP is acked only after the IDLE that follows the rsp_ready=1 cycle.
- Timeout: lut_done never asserted, TIMEOUT=64 → rsp_valid with rsp_timeout=1 and rsp_value=0 exactly 64 cycles after WAIT entry. A lut_done pulsed 3 cycles later produces no second response.
- Simultaneous done and timeout: lut_done on the wd_cnt==TIMEOUT-1 cycle → rsp_timeout=0 and rsp_value=lut_value.
- Reset mid-WAIT: assert reset_n=0 asynchronously while in WAIT → all outputs 0 immediately, state IDLE; after release, req=4'b0010 is granted with ack[1] and rr_ptr starts from 0.
